// File: rtl/hilo_mult_if.sv
// Handshake and result bundle between the EX-stage control logic and the
// HI/LO multiply sequencer.
interface hilo_mult_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       regsel_EX;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hilo_rdata;
  logic             busy;
  logic             done;
  logic             stall_req;

  modport master (
    output start, is_signed, op_a, op_b, regsel_EX,
    input  hi, lo, hilo_rdata, busy, done, stall_req
  );

  modport slave (
    input  start, is_signed, op_a, op_b, regsel_EX,
    output hi, lo, hilo_rdata, busy, done, stall_req
  );
endinterface

// File: rtl/hilo_mult_sequencer.sv
// Iterative shift-add multiplier that owns the HI/LO registers for mult/multu.
// The multiply takes WIDTH CALC cycles plus one SIGN cycle, and stalls hazards meanwhile.
module hilo_mult_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  hilo_mult_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_e;

  state_e             state_q,  state_d;
  logic [WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   hi_q,     hi_d;
  logic [WIDTH-1:0]   lo_q,     lo_d;
  logic [2*WIDTH:0]   acc_q,    acc_d;
  logic [CW-1:0]      count_q,  count_d;
  logic               neg_q,    neg_d;
  logic               done_q,   done_d;

  logic [2*WIDTH:0]   acc_sum;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    count_d  = count_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    acc_sum  = '0;
    product  = '0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CALC;
          count_d = '0;
          acc_d   = '0;
          if (bus.is_signed) begin
            // |-2^(W-1)| wraps to 2^(W-1), which is exactly right as an unsigned magnitude.
            mcand_d  = bus.op_a[WIDTH-1] ? -bus.op_a : bus.op_a;
            mplier_d = bus.op_b[WIDTH-1] ? -bus.op_b : bus.op_b;
            neg_d    = bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1];
          end else begin
            mcand_d  = bus.op_a;
            mplier_d = bus.op_b;
            neg_d    = 1'b0;
          end
        end
      end

      CALC: begin
        // The extra accumulator bit catches the carry out of the upper-half add.
        acc_sum  = acc_q + (mplier_q[0] ? {1'b0, mcand_q, {WIDTH{1'b0}}} : '0);
        acc_d    = acc_sum >> 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = SIGN;
        end
      end

      SIGN: begin
        product = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
        hi_d    = product[2*WIDTH-1:WIDTH];
        lo_d    = product[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    if (!rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
    end
  end

  assign busy          = (state_q == CALC) || (state_q == SIGN);
  assign bus.busy      = busy;
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.stall_req = busy && (bus.start || (bus.regsel_EX == 2'd1) || (bus.regsel_EX == 2'd2));

  // Regsel 3 is reserved and reads as zero, same as "no read".
  always_comb begin
    case (bus.regsel_EX)
      2'd1:    bus.hilo_rdata = hi_q;
      2'd2:    bus.hilo_rdata = lo_q;
      default: bus.hilo_rdata = '0;
    endcase
  end
endmodule

// File: tb/tb_hilo_mult_sequencer.sv
// Directed bench for the HI/LO multiply sequencer: stimulus pushes expected
// HI/LO pairs into a queue and a monitor pops them whenever done pulses.
module tb_hilo_mult_sequencer;
  localparam int WIDTH = 32;

  typedef struct {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
  } exp_t;

  logic clk;
  logic rst;
  hilo_mult_if #(.WIDTH(WIDTH)) bus ();

  hilo_mult_sequencer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks   = 0;
  int   n_pass     = 0;
  int   n_done     = 0;
  int   n_expected = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  exp_t mon_e;
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("done_unexpected", 64'(bus.done), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_hi", 64'(bus.hi), 64'(mon_e.hi));
        check("result_lo", 64'(bus.lo), 64'(mon_e.lo));
      end
    end
  end

  // Presents one operation for the accepting edge, then scrambles the
  // operand inputs so any result depending on them after acceptance is wrong.
  task automatic start_op(input bit sgn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] eh, input logic [WIDTH-1:0] el,
                          input bit expect_res);
    exp_t e;
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.op_a      = a;
    bus.op_b      = b;
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.is_signed = ~sgn;
    bus.op_a      = ~a;
    bus.op_b      = ~b;
    if (expect_res) begin
      e.hi = eh;
      e.lo = el;
      exp_q.push_back(e);
      n_expected++;
    end
  endtask

  // Called in cycle 1; checks cycles 1..WIDTH+1 (busy) and returns mid-cycle WIDTH+2 (done).
  task automatic wait_result(input bit exp_stall, input bit chk_rdata, input logic [WIDTH-1:0] old_rdata);
    for (int i = 1; i <= WIDTH + 1; i++) begin
      @(negedge clk);
      check("busy_high", 64'(bus.busy), 64'd1);
      check("stall_req_busy", 64'(bus.stall_req), 64'(exp_stall));
      check("done_low_busy", 64'(bus.done), 64'd0);
      if (chk_rdata) check("rdata_old", 64'(bus.hilo_rdata), 64'(old_rdata));
    end
    @(negedge clk);
    check("done_pulse", 64'(bus.done), 64'd1);
    check("busy_clear", 64'(bus.busy), 64'd0);
    check("stall_clear", 64'(bus.stall_req), 64'd0);
  endtask

  task automatic done_single();
    @(negedge clk);
    check("done_single_cycle", 64'(bus.done), 64'd0);
  endtask

  task automatic run(input bit sgn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                     input logic [WIDTH-1:0] eh, input logic [WIDTH-1:0] el);
    start_op(sgn, a, b, eh, el, 1'b1);
    wait_result(1'b0, 1'b0, '0);
    done_single();
  endtask

  initial begin
    rst           = 1'b0;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.regsel_EX = 2'd0;

    // Power-on reset
    @(posedge clk);
    @(negedge clk);
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Unsigned max x max, then idle reads of the new HI/LO
    run(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    bus.regsel_EX = 2'd1;
    #1 check("idle_rdata_hi", 64'(bus.hilo_rdata), 64'hFFFF_FFFE);
    check("idle_no_stall", 64'(bus.stall_req), 64'd0);
    bus.regsel_EX = 2'd2;
    #1 check("idle_rdata_lo", 64'(bus.hilo_rdata), 64'h0000_0001);
    bus.regsel_EX = 2'd3;
    #1 check("idle_rdata_rsvd", 64'(bus.hilo_rdata), 64'd0);
    bus.regsel_EX = 2'd0;

    // Reset for two cycles mid-multiply aborts and clears HI/LO
    start_op(1'b0, 32'd7, 32'd9, '0, '0, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort_hi", 64'(bus.hi), 64'd0);
    check("abort_lo", 64'(bus.lo), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);

    // Signed cases, including the most-negative corner and a zero operand
    run(1'b1, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(1'b1, 32'hFFFF_FFFA, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFD6);
    run(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run(1'b1, 32'd0,         32'h1234_5678, 32'h0000_0000, 32'h0000_0000);

    // mflo hazard while busy: stall and old LO (0) shown, then new LO at done
    start_op(1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1);
    bus.regsel_EX = 2'd2;
    wait_result(1'b1, 1'b1, 32'd0);
    check("hazard_rdata_lo", 64'(bus.hilo_rdata), 64'h0000_000F);
    bus.regsel_EX = 2'd1;
    #1 check("hazard_rdata_hi", 64'(bus.hilo_rdata), 64'd0);
    check("hazard_idle_stall", 64'(bus.stall_req), 64'd0);
    bus.regsel_EX = 2'd0;
    done_single();

    // Back-to-back: start held high; operand changes while busy are ignored
    begin
      exp_t e;
      bus.start     = 1'b1;
      bus.is_signed = 1'b0;
      bus.op_a      = 32'd2;
      bus.op_b      = 32'd3;
      @(posedge clk);
      #1;
      e.hi = 32'd0; e.lo = 32'd6;
      exp_q.push_back(e);
      n_expected++;
      bus.op_a = 32'd4;
      bus.op_b = 32'd5;
      wait_result(1'b1, 1'b0, '0);
      e.hi = 32'd0; e.lo = 32'd20;
      exp_q.push_back(e);
      n_expected++;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.op_a  = 32'h0000_DEAD;
      bus.op_b  = 32'h0000_BEEF;
      wait_result(1'b0, 1'b0, '0);
      done_single();
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    check("done_count", 64'(n_done), 64'(n_expected));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
